// File: rtl/dlfloat_pkg.sv
// DLFloat16 format constants, controller states and the multiply/add arithmetic
// shared by the streaming MAC.
package dlfloat_pkg;

  localparam int DLF_W = 16;
  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;

  localparam logic [15:0] DLF_ZERO    = 16'h0000;
  localparam logic [15:0] DLF_SPECIAL = 16'hFFFF;
  localparam logic [14:0] DLF_SAT_MAG = 15'h7DFF;

  typedef enum logic [1:0] {LD_A, LD_B, WAIT, EMIT} state_t;

  // Range-checks an exponent: overflow saturates (flag set), underflow flushes to zero.
  function automatic logic [16:0] dlf_pack(input logic s, input logic signed [9:0] e,
                                           input logic [MAN_W-1:0] m);
    if (e > 10'sd62)
      return {1'b1, s, DLF_SAT_MAG};
    else if (e < 10'sd1)
      return {1'b0, DLF_ZERO};
    else
      return {1'b0, s, e[EXP_W-1:0], m};
  endfunction

  function automatic logic [16:0] dlf_mul(input logic [15:0] a, input logic [15:0] b);
    logic [19:0]       p;
    logic signed [9:0] e;
    logic [MAN_W-1:0]  m;
    if (a == DLF_SPECIAL || b == DLF_SPECIAL)
      return {1'b0, DLF_SPECIAL};
    if (a == DLF_ZERO || b == DLF_ZERO)
      return {1'b0, DLF_ZERO};
    p = 20'({1'b1, a[MAN_W-1:0]}) * 20'({1'b1, b[MAN_W-1:0]});
    e = $signed({4'b0, a[14:9]}) + $signed({4'b0, b[14:9]}) - $signed(10'(BIAS));
    if (p[19]) begin
      e = e + 10'sd1;
      m = p[18:10];
    end else begin
      m = p[17:9];
    end
    return dlf_pack(a[15] ^ b[15], e, m);
  endfunction

  function automatic logic [16:0] dlf_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       hi;
    logic [15:0]       lo;
    logic [5:0]        sh;
    logic [10:0]       ml;
    logic [10:0]       ms;
    logic [10:0]       r;
    logic signed [9:0] e;
    if (a == DLF_SPECIAL || b == DLF_SPECIAL)
      return {1'b0, DLF_SPECIAL};
    if (a == DLF_ZERO)
      return {1'b0, b};
    if (b == DLF_ZERO)
      return {1'b0, a};
    if (a[14:0] >= b[14:0]) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    sh = hi[14:9] - lo[14:9];
    ml = {2'b01, hi[MAN_W-1:0]};
    ms = {2'b01, lo[MAN_W-1:0]} >> sh;
    e  = $signed({4'b0, hi[14:9]});
    if (hi[15] == lo[15])
      r = ml + ms;
    else
      r = ml - ms;
    if (r == 11'd0)
      return {1'b0, DLF_ZERO};
    if (r[10]) begin
      e = e + 10'sd1;
      r = r >> 1;
    end else begin
      // Leading-one search: at most nine left shifts bring the MSB to bit 9.
      for (int i = 0; i < 9; i++) begin
        if (!r[9]) begin
          r = r << 1;
          e = e - 10'sd1;
        end
      end
    end
    return dlf_pack(hi[15], e, r[MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/dlfloat_mac_stream_ser.sv
// Word-to-beat serializer with valid/ready handshake; MSB beat first, last flag
// on the final beat, done pulses on the final transfer.
module dlfloat_beat_ser #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic [BUS_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  localparam int NBEATS = DATA_W / BUS_W;
  localparam int KW     = $clog2(NBEATS + 1);

  logic [DATA_W-1:0] shreg_p2;
  logic [KW-1:0]     k;
  logic              vld_p2;
  logic              xfer;

  assign xfer      = vld_p2 && out_ready;
  assign out_valid = vld_p2;
  assign out_last  = vld_p2 && (k == KW'(NBEATS - 1));
  assign done      = xfer && out_last;
  assign out_data  = vld_p2 ? shreg_p2[DATA_W-1 -: BUS_W] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      vld_p2 <= 1'b0;
      k      <= '0;
    end else if (load) begin
      vld_p2 <= 1'b1;
      k      <= '0;
    end else if (xfer) begin
      if (out_last)
        vld_p2 <= 1'b0;
      k <= k + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load)
      shreg_p2 <= load_data;
    else if (xfer)
      shreg_p2 <= shreg_p2 << BUS_W;
  end

endmodule

// File: rtl/dlfloat_mac_stream.sv
// Streaming DLFloat16 dot-product engine: beat-serial operand pairs in, one
// accumulated result out every ACC_LEN pairs.
module dlfloat_mac_stream
  import dlfloat_pkg::*;
#(
  parameter int BUS_W   = 8,
  parameter int ACC_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             sat
);

  localparam int BEATS = DLF_W / BUS_W;

  state_t           st;
  state_t           st_nxt;
  logic [1:0]       beat_cnt;
  logic [CNT_W-1:0] pair_cnt;
  logic [DLF_W-1:0] a_p0;
  logic [DLF_W-1:0] b_p0;
  logic [DLF_W-1:0] b_full;
  logic [16:0]      prod_p1;
  logic             vld_p1;
  logic             last_p1;
  logic [DLF_W-1:0] acc_p2;
  logic [16:0]      sum;
  logic             in_xfer;
  logic             last_beat;
  logic             last_pair;
  logic             launch;
  logic             ser_load;
  logic             ser_done;

  assign in_ready  = rst_n && (st == LD_A || st == LD_B);
  assign in_xfer   = in_valid && in_ready;
  assign last_beat = beat_cnt == 2'(BEATS - 1);
  assign last_pair = pair_cnt == CNT_W'(ACC_LEN - 1);
  assign launch    = in_xfer && st == LD_B && last_beat;
  assign b_full    = DLF_W'({b_p0, in_data});
  assign sum       = dlf_add(acc_p2, prod_p1[15:0]);
  assign ser_load  = vld_p1 && last_p1;
  assign busy      = !(st == LD_A && pair_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)
      st <= LD_A;
    else
      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      LD_A:    if (in_xfer && last_beat) st_nxt = LD_B;
      LD_B:    if (launch) st_nxt = last_pair ? WAIT : LD_A;
      WAIT:    if (ser_load) st_nxt = EMIT;
      EMIT:    if (ser_done) st_nxt = LD_A;
      default: st_nxt = LD_A;
    endcase
    if (clear)
      st_nxt = LD_A;
  end

  // Stage 0: operand assembly; stage 1: product register.
  always_ff @(posedge clk) begin
    if (in_xfer && st == LD_A)
      a_p0 <= DLF_W'({a_p0, in_data});
    if (in_xfer && st == LD_B)
      b_p0 <= b_full;
    if (launch) begin
      prod_p1 <= dlf_mul(a_p0, b_full);
      last_p1 <= last_pair;
    end
  end

  // Stage 2: accumulator, sticky saturation and counters.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      beat_cnt <= '0;
      pair_cnt <= '0;
      vld_p1   <= 1'b0;
      acc_p2   <= DLF_ZERO;
      sat      <= 1'b0;
    end else begin
      vld_p1 <= launch;
      if (in_xfer)
        beat_cnt <= last_beat ? 2'd0 : beat_cnt + 2'd1;
      if (launch && !last_pair)
        pair_cnt <= pair_cnt + CNT_W'(1);
      if (vld_p1) begin
        acc_p2 <= sum[15:0];
        sat    <= sat | prod_p1[16] | sum[16];
      end
      if (ser_done) begin
        acc_p2   <= DLF_ZERO;
        pair_cnt <= '0;
        sat      <= 1'b0;
      end
    end
  end

  dlfloat_beat_ser #(
    .DATA_W(DLF_W),
    .BUS_W (BUS_W)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .load     (ser_load),
    .load_data(sum[15:0]),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_dlfloat_mac_stream.sv
// Scoreboard bench for dlfloat_mac_stream (BUS_W=8, ACC_LEN=4) using directed
// vectors with hand-computed results.
module tb_dlfloat_mac_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       sat;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       sat;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  always #5 clk = ~clk;

  dlfloat_mac_stream #(
    .BUS_W  (8),
    .ACC_LEN(4),
    .CNT_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .sat      (sat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h expected=none", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.data));
        chk("out_last", 32'(out_last), 32'(mon_e.last));
        chk("sat", 32'(sat), 32'(mon_e.sat));
      end
    end
  end

  task automatic push_result(input logic [15:0] v, input logic s);
    exp_q.push_back('{data: v[15:8], last: 1'b0, sat: s});
    exp_q.push_back('{data: v[7:0], last: 1'b1, sat: s});
  endtask

  task automatic send_beat(input logic [7:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input bit fin);
    send_beat(a[15:8]);
    send_beat(a[7:0]);
    send_beat(b[15:8]);
    send_beat(b[7:0]);
    chk("in_ready_after_pair", 32'(in_ready), fin ? 32'd0 : 32'd1);
    if (fin) begin
      chk("out_valid_t1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("out_valid_t2", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    chk("busy_after_emit", 32'(busy), 32'd0);
    chk("sat_after_emit", 32'(sat), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1.0 x 2.0 with zero padding pairs
    push_result(16'h4000, 1'b0);
    send_pair(16'h0000, 16'h0000, 0);
    send_pair(16'h0000, 16'h0000, 0);
    send_pair(16'h0000, 16'h0000, 0);
    send_pair(16'h3E00, 16'h4000, 1);
    wait_drain();

    // four back-to-back 1.0 x 1.0 -> 4.0
    push_result(16'h4200, 1'b0);
    for (int i = 0; i < 4; i++) send_pair(16'h3E00, 16'h3E00, i == 3);
    wait_drain();

    // +3.0 then -3.0 cancels
    push_result(16'h0000, 1'b0);
    send_pair(16'h3F00, 16'h4000, 0);
    send_pair(16'hBF00, 16'h4000, 0);
    send_pair(16'h0000, 16'h0000, 0);
    send_pair(16'h0000, 16'h0000, 1);
    wait_drain();

    // 1.5*1.5 + 1.0*-1.0 = 1.25
    push_result(16'h3E80, 1'b0);
    send_pair(16'h3F00, 16'h3F00, 0);
    send_pair(16'h3E00, 16'hBE00, 0);
    send_pair(16'h0000, 16'h0000, 0);
    send_pair(16'h0000, 16'h0000, 1);
    wait_drain();

    // special operand absorbs
    push_result(16'hFFFF, 1'b0);
    send_pair(16'hFFFF, 16'h3E00, 0);
    for (int i = 0; i < 3; i++) send_pair(16'h3E00, 16'h3E00, i == 2);
    wait_drain();

    // multiply overflow saturates
    push_result(16'h7DFF, 1'b1);
    send_pair(16'h7C00, 16'h7C00, 0);
    for (int i = 0; i < 3; i++) send_pair(16'h0000, 16'h0000, i == 2);
    wait_drain();

    // add overflow saturates
    push_result(16'h7DFF, 1'b1);
    for (int i = 0; i < 4; i++) send_pair(16'h7C00, 16'h3E00, i == 3);
    wait_drain();

    // backpressure during EMIT
    out_ready = 1'b0;
    push_result(16'h4200, 1'b0);
    for (int i = 0; i < 4; i++) send_pair(16'h3E00, 16'h3E00, i == 3);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'h42);
      chk("bp_out_last", 32'(out_last), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // clear after two pairs, with a beat offered in the clear cycle
    send_pair(16'h7C00, 16'h7C00, 0);
    send_pair(16'h4000, 16'h4000, 0);
    chk("sat_before_clear", 32'(sat), 32'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3E;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_busy", 32'(busy), 32'd0);
    chk("clear_sat", 32'(sat), 32'd0);
    chk("clear_in_ready", 32'(in_ready), 32'd1);
    push_result(16'h4200, 1'b0);
    for (int i = 0; i < 4; i++) send_pair(16'h3E00, 16'h3E00, i == 3);
    wait_drain();

    // reset in the middle of EMIT
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pair(16'h3E00, 16'h3E00, i == 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    chk("mrst_out_last", 32'(out_last), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_sat", 32'(sat), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // recovery
    push_result(16'h4000, 1'b0);
    send_pair(16'h3E00, 16'h4000, 0);
    for (int i = 0; i < 3; i++) send_pair(16'h0000, 16'h3E00, i == 2);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
